// File: rtl/parallel_serial_pkg.sv
// Shared encodings for the buffered parallel-to-serial transmitter.
package parallel_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_DATA   = 2'd2,
    ST_PARITY = 2'd3
  } ps_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

endpackage

// File: rtl/ps_frame_fifo.sv
// Frame queue with the head entry visible combinationally so IDLE can load on the pop edge.
module ps_frame_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push, w_pop;

  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && (r_cnt != CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_wdata;

  // Pointers are exactly log2(DEPTH) bits, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/parallel_serial_buffered.sv
// Queued frames serialised MSB-first behind a start bit, with optional even parity.
module parallel_serial_buffered
  import parallel_serial_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = PARITY_NONE,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dv_in,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [LEN_WIDTH-1:0]  bit_length,
  output logic                  in_ready,
  output logic                  dout,
  output logic                  dout_en,
  output logic                  data_sent,
  output logic                  busy,
  output logic [CW-1:0]         fifo_count
);
  localparam int FW = DATA_WIDTH + LEN_WIDTH;

  ps_state_e             r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_buf, w_buf_nxt;
  logic [LEN_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic                  r_par, w_par_nxt;
  logic                  r_dout, w_dout_nxt, r_en, w_en_nxt, r_sent, w_sent_nxt;

  logic [FW-1:0]         w_head;
  logic [DATA_WIDTH-1:0] w_head_din;
  logic [LEN_WIDTH-1:0]  w_head_len, w_len, w_shift;
  logic                  w_empty, w_push, w_pop;

  assign in_ready   = (fifo_count < CW'(FIFO_DEPTH));
  assign w_push     = dv_in && in_ready;
  assign w_head_din = w_head[FW-1:LEN_WIDTH];
  assign w_head_len = w_head[LEN_WIDTH-1:0];
  assign w_len      = (w_head_len > LEN_WIDTH'(DATA_WIDTH)) ? LEN_WIDTH'(DATA_WIDTH) : w_head_len;
  assign w_shift    = LEN_WIDTH'(DATA_WIDTH) - w_len;
  // Zero-length entries are discarded from the head in any state so they cost no line gap.
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) || (w_head_len == '0));

  ps_frame_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({din, bit_length}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  // Payload is left-aligned at load so the next bit is always the buffer MSB.
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    w_dout_nxt  = 1'b0;
    w_en_nxt    = 1'b0;
    w_sent_nxt  = 1'b0;
    unique case (r_state)
      ST_IDLE:
        if (!w_empty && (w_len != '0)) begin
          w_state_nxt = ST_START;
          w_buf_nxt   = w_head_din << w_shift;
          w_cnt_nxt   = w_len - LEN_WIDTH'(1);
          w_par_nxt   = 1'b0;
          w_en_nxt    = 1'b1;
        end
      ST_START: begin
        w_state_nxt = ST_DATA;
        w_en_nxt    = 1'b1;
        w_dout_nxt  = r_buf[DATA_WIDTH-1];
        w_par_nxt   = r_par ^ r_buf[DATA_WIDTH-1];
        w_buf_nxt   = r_buf << 1;
      end
      ST_DATA:
        if (r_cnt == '0) begin
          if (PARITY_EN == PARITY_EVEN) begin
            w_state_nxt = ST_PARITY;
            w_en_nxt    = 1'b1;
            w_dout_nxt  = r_par;
          end else begin
            w_state_nxt = ST_IDLE;
            w_sent_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt  = r_cnt - LEN_WIDTH'(1);
          w_en_nxt   = 1'b1;
          w_dout_nxt = r_buf[DATA_WIDTH-1];
          w_par_nxt  = r_par ^ r_buf[DATA_WIDTH-1];
          w_buf_nxt  = r_buf << 1;
        end
      ST_PARITY: begin
        w_state_nxt = ST_IDLE;
        w_sent_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
      r_dout  <= 1'b0;
      r_en    <= 1'b0;
      r_sent  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_buf   <= w_buf_nxt;
      r_cnt   <= w_cnt_nxt;
      r_par   <= w_par_nxt;
      r_dout  <= w_dout_nxt;
      r_en    <= w_en_nxt;
      r_sent  <= w_sent_nxt;
    end
  end

  assign dout      = r_dout;
  assign dout_en   = r_en;
  assign data_sent = r_sent;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_parallel_serial_buffered.sv
// Directed checks on two instances (no parity / even parity) fed the same frames.
module tb_parallel_serial_buffered;
  localparam int DW = 16, LW = 5, FD = 4, CW = $clog2(FD + 1);

  logic          clk = 1'b0, rst = 1'b1, dv_in = 1'b0;
  logic [DW-1:0] din = '0;
  logic [LW-1:0] bit_length = '0;
  logic          rdy0, dout0, en0, sent0, busy0;
  logic          rdy1, dout1, en1, sent1, busy1;
  logic [CW-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  parallel_serial_buffered #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .dv_in(dv_in), .din(din), .bit_length(bit_length), .in_ready(rdy0),
    .dout(dout0), .dout_en(en0), .data_sent(sent0), .busy(busy0), .fifo_count(cnt0));

  parallel_serial_buffered #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .dv_in(dv_in), .din(din), .bit_length(bit_length), .in_ready(rdy1),
    .dout(dout1), .dout_en(en1), .data_sent(sent1), .busy(busy1), .fifo_count(cnt1));

  int n_cmp = 0, n_err = 0;

  // Line monitor: shifts in every driven bit, counts pulses and the idle gap between frames.
  logic        clr = 1'b0;
  logic [63:0] seq0, seq1;
  int          nb0, nb1, ns0, ns1, idle0, gap0;
  logic        seen0;
  always @(negedge clk) begin
    if (clr) begin
      seq0 <= '0; seq1 <= '0; nb0 <= 0; nb1 <= 0; ns0 <= 0; ns1 <= 0;
      idle0 <= 0; gap0 <= -1; seen0 <= 1'b0;
    end else begin
      if (en0) begin
        seq0 <= {seq0[62:0], dout0}; nb0 <= nb0 + 1;
        if (seen0 && idle0 > 0) gap0 <= idle0;
        idle0 <= 0; seen0 <= 1'b1;
      end else idle0 <= idle0 + 1;
      if (en1) begin seq1 <= {seq1[62:0], dout1}; nb1 <= nb1 + 1; end
      if (sent0) ns0 <= ns0 + 1;
      if (sent1) ns1 <= ns1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic clear();
    @(negedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d, input logic [LW-1:0] l);
    din = d; bit_length = l; dv_in = 1'b1;
    @(posedge clk); #1 dv_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy0 && !busy1 && cnt0 == '0 && cnt1 == '0) done = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1 chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #2;
    chk("rst_en",    64'(en0),   64'd0);
    chk("rst_dout",  64'(dout0), 64'd0);
    chk("rst_busy",  64'(busy0), 64'd0);
    chk("rst_cnt",   64'(cnt0),  64'd0);
    chk("rst_rdy",   64'(rdy0),  64'd1);
    chk("rst_sent",  64'(sent0), 64'd0);
    @(negedge clk); rst = 1'b0;
    clear();

    // A5C3, 8 bits: start then C3 MSB-first; latency start bit after E1
    push(16'hA5C3, 5'd8);
    @(negedge clk);
    chk("lat_e0_en",  64'(en0),  64'd0);
    chk("lat_e0_cnt", 64'(cnt0), 64'd1);
    @(negedge clk);
    chk("lat_e1_en",   64'(en0),   64'd1);
    chk("lat_e1_dout", 64'(dout0), 64'd0);
    chk("lat_e1_busy", 64'(busy0), 64'd1);
    drain("t1_drain");
    chk("t1_bits", 64'(nb0), 64'd9);
    chk("t1_seq",  seq0,     64'h0C3);
    chk("t1_sent", 64'(ns0), 64'd1);

    // parity: 111 -> parity 1; 101 -> parity 0
    clear();
    push(16'h0007, 5'd3);
    drain("t2a_drain");
    chk("t2a_bits1", 64'(nb1), 64'd5);
    chk("t2a_seq1",  seq1,     64'h0F);
    chk("t2a_sent1", 64'(ns1), 64'd1);
    chk("t2a_seq0",  seq0,     64'h07);
    clear();
    push(16'h0005, 5'd3);
    drain("t2b_drain");
    chk("t2b_seq1",  seq1,     64'h0A);
    chk("t2b_bits1", 64'(nb1), 64'd5);

    // overflow: blocker frame then 5 more; the 5th must be dropped
    clear();
    push(16'hFFFF, 5'd16);
    push(16'h0001, 5'd2);
    push(16'h0002, 5'd2);
    push(16'h0003, 5'd2);
    push(16'h0001, 5'd2);
    chk("t3_cnt_full", 64'(cnt0), 64'd4);
    chk("t3_rdy_full", 64'(rdy0), 64'd0);
    push(16'h0002, 5'd2);
    chk("t3_cnt_after", 64'(cnt0), 64'd4);
    drain("t3_drain");
    chk("t3_bits", 64'(nb0), 64'd29);
    chk("t3_tail", seq0 & 64'hFFF, 64'h299);
    chk("t3_sent", 64'(ns0), 64'd5);

    // zero-length entry between two 4-bit frames
    clear();
    push(16'h000A, 5'd4);
    push(16'h1234, 5'd0);
    push(16'h0005, 5'd4);
    drain("t4_drain");
    chk("t4_bits", 64'(nb0),  64'd10);
    chk("t4_seq",  seq0,      64'h145);
    chk("t4_sent", 64'(ns0),  64'd2);
    chk("t4_gap",  64'(gap0), 64'd1);

    // length clamp: 31 -> 16
    clear();
    push(16'hBEEF, 5'd31);
    drain("t5_drain");
    chk("t5_bits", 64'(nb0), 64'd17);
    chk("t5_seq",  seq0,     64'hBEEF);
    chk("t5_sent", 64'(ns0), 64'd1);

    // reset on 3rd payload bit with two frames queued
    clear();
    push(16'h00FF, 5'd8);
    push(16'h00AA, 5'd8);
    push(16'h0055, 5'd8);
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1;
    chk("t6_en_pre",   64'(en0),  64'd1);
    chk("t6_cnt_pre",  64'(cnt0), 64'd2);
    chk("t6_bits_pre", 64'(nb0),  64'd4);
    rst = 1'b1; #1;
    chk("t6_en",   64'(en0),   64'd0);
    chk("t6_cnt",  64'(cnt0),  64'd0);
    chk("t6_rdy",  64'(rdy0),  64'd1);
    chk("t6_busy", 64'(busy0), 64'd0);
    chk("t6_dout", 64'(dout0), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("t6_bits_post", 64'(nb0), 64'd4);
    chk("t6_sent",      64'(ns0), 64'd0);
    chk("t6_sent1",     64'(ns1), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parallel_serial_buffered.md
PARALLEL_SERIAL_BUFFERED -- requirements
Module: parallel_serial_buffered

Interface
REQ-001 Parameter DATA_WIDTH, 16: maximum payload bits per frame.
REQ-002 Parameter LEN_WIDTH, 5: width of bit_length, covering 0..DATA_WIDTH.
REQ-003 Parameter FIFO_DEPTH, 4: queued frames, power of two, >=2.
REQ-004 Parameter PARITY_EN, 0: 1 appends one even-parity bit per frame.
REQ-005 Port clk  input  1: single clock; all logic on rising edge.
REQ-006 Port rst  input  1: asynchronous, active-high reset.
REQ-007 Port dv_in  input  1: frame-valid strobe.
REQ-008 Port din  input  DATA_WIDTH: payload; bit_length-1 is first bit sent.
REQ-009 Port bit_length  input  LEN_WIDTH: payload bits for this frame.
REQ-010 Port in_ready  output  1: FIFO can accept a frame.
REQ-011 Port dout  output  1: serial data.
REQ-012 Port dout_en  output  1: line-drive enable; dout is don't-care when 0.
REQ-013 Port data_sent  output  1: one-cycle pulse after each completed frame.
REQ-014 Port busy  output  1: FSM not in IDLE.
REQ-015 Port fifo_count  output  clog2(FIFO_DEPTH+1): queued frames.

Function
REQ-016 The block SHALL write {din, bit_length} into the FIFO on an edge where dv_in=1 and in_ready=1; dv_in with in_ready=0 SHALL be dropped.
REQ-017 in_ready SHALL equal (fifo_count < FIFO_DEPTH); no bypass around the FIFO.
REQ-018 Simultaneous push and pop SHALL leave fifo_count unchanged, including when full.
REQ-019 FSM states: IDLE, START, DATA, PARITY.
REQ-020 IDLE: if FIFO non-empty, pop head, load shift buffer and counter=len-1, go START; else stay.
REQ-021 START: dout=0, dout_en=1 for one cycle, then DATA.
REQ-022 DATA: drive buffer[counter] MSB-first; decrement per cycle; at counter 0 go PARITY if PARITY_EN else IDLE.
REQ-023 PARITY: drive XOR of the transmitted payload bits for one cycle, then IDLE.
REQ-024 dout and dout_en SHALL be registered, updated on the edge entering each state; dout_en=0 in IDLE.
REQ-025 IDLE SHALL last at least one cycle between frames (one-cycle gap back-to-back).
REQ-026 data_sent SHALL pulse for the first IDLE cycle following a DATA or PARITY state only.
REQ-027 Latency: frame accepted at edge E0 into empty FIFO with FSM idle -> start bit after E1, first payload bit after E2, last after E(1+len).
REQ-028 bit_length=0: entry SHALL be popped and discarded, no start bit, no data_sent.
REQ-029 bit_length>DATA_WIDTH SHALL be clamped to DATA_WIDTH.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, FIFO empty, fifo_count=0, in_ready=1, dout=0, dout_en=0, data_sent=0, busy=0, shift buffer and counter zero.
REQ-032 Reset mid-frame SHALL abandon the frame and all queued frames without a data_sent pulse.

Structure
REQ-033 State encoding and the parity-mode constants SHALL live in shared package parallel_serial_pkg.
REQ-034 Frame storage SHALL be sub-module ps_frame_fifo (synchronous, width DATA_WIDTH+LEN_WIDTH, depth FIFO_DEPTH).

Verification
REQ-035 din=16'hA5C3, len=8, PARITY_EN=0 -> dout_en high 9 cycles, dout 0,1,1,0,0,0,0,1,1; data_sent once.
REQ-036 PARITY_EN=1, din=16'h0007, len=3 -> start 0, data 1,1,1, parity 1.
REQ-037 Push 5 frames back-to-back, FIFO_DEPTH=4, FSM blocked -> 5th dropped while in_ready=0, fifo_count peaks at 4, exactly 4 frames emitted.
REQ-038 len=0 queued between two len=4 frames -> two frames on line, two data_sent pulses, one-cycle gap only.
REQ-039 rst asserted at 3rd payload bit with 2 frames queued -> dout_en=0 same cycle, fifo_count=0, no further output.
REQ-040 len=31 with DATA_WIDTH=16 -> exactly 16 payload bits sent.
